boot_loader: RTL

Boot-time instruction memory loader sitting directly upstream of the single-cycle processor top. Accepts a byte stream (from a UART receiver or testbench) over a valid/ready handshake, packs bytes into 32-bit words, and writes them sequentially into instruction memory. It holds the processor in reset through `cpu_rst_n` until the image is fully loaded, then releases it.

---
 rtl/boot_pkg.sv | 23 ++
 rtl/word_packer.sv | 54 +++++
 rtl/boot_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package boot_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int WCOUNT_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } boot_state_t;

    function automatic logic [31:0] word_addr(input logic [WCOUNT_W-1:0] idx);
        return {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/word_packer.sv
// Packs an MSB-first byte stream into 32-bit words for the boot loader.
module word_packer
    import boot_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_in,
    input  logic                          consume,
    output logic                          word_last,
    output logic                          word_full,
    output logic [8*BYTES_PER_WORD-1:0]   word_data
);

    localparam int CNT_W  = $clog2(BYTES_PER_WORD);
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              full_q, full_d;

    assign word_last = byte_valid && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_full = full_q;
    assign word_data = word_q;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        full_d = full_q;
        if (consume) begin
            full_d = 1'b0;
        end
        if (byte_valid) begin
            word_d = {word_q[WORD_W-9:0], byte_in};
            cnt_d  = cnt_q + CNT_W'(1);
            if (word_last) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed byte image into instruction memory, then releases cpu_rst_n.
// Optional trailing checksum byte when BOOT_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | one settle cycle after reset
// HDR_HI  | accept word count [15:8]
// HDR_LO  | accept word count [7:0], size check
// DATA    | accept payload bytes into the packer
// WRITE   | one-cycle imem write of the packed word
// CHK     | accept and compare checksum byte
// DONE    | image loaded, processor released
// ERR     | load aborted, processor held in reset
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    boot_state_t state_q, state_d;
    boot_state_t fin_state;

    logic [8*HDR_BYTES-1:0] count_q, count_d;
    logic [WCOUNT_W-1:0]    hdr_count;
    logic [WCOUNT_W-1:0]    idx_q, idx_d, idx_inc;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;
    logic cpu_rst_n_q, cpu_rst_n_d;

    logic        byte_valid, consume, word_last, word_full;
    logic [31:0] word_data;

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_in    (rx_data),
        .consume    (consume),
        .word_last  (word_last),
        .word_full  (word_full),
        .word_data  (word_data)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    assign fin_state = S_CHK;
`else
    assign fin_state = S_DONE;
`endif

    assign hdr_count = {count_q[15:8], rx_data};
    assign idx_inc   = idx_q + WCOUNT_W'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        rx_ready   = 1'b0;
        byte_valid = 1'b0;
        consume    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_HDR_HI;
            S_HDR_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    count_d = {rx_data, count_q[7:0]};
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    count_d = hdr_count;
                    if (hdr_count == '0) begin
                        state_d = fin_state;
                    end else if (32'(hdr_count) > IMEM_DEPTH_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready   = 1'b1;
                byte_valid = rx_valid;
`ifdef BOOT_CHECKSUM_EN
                if (rx_valid) begin
                    sum_d = sum_q + rx_data;
                end
`endif
                if (word_last) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                consume = 1'b1;
                idx_d   = idx_inc;
                state_d = (idx_inc == count_q) ? fin_state : S_DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags lag the state by one cycle so done/cpu_rst_n rise two edges after the last byte.
    always_comb begin
        busy_d      = !(state_q inside {S_DONE, S_ERR});
        done_d      = (state_q == S_DONE);
        error_d     = (state_q == S_ERR);
        cpu_rst_n_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign imem_we    = (state_q == S_WRITE) && word_full;
    assign imem_addr  = word_addr(idx_q);
    assign imem_wdata = word_data;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_rst_n  = cpu_rst_n_q;

endmodule
